nadajnik: RTL and testbench
===========================

Name: nadajnik

Overview:
- RS-232/UART serial transmitter: the transmit-side counterpart of the odbiornik receiver.
- Accepts one parallel word per valid/ready handshake and serialises it on TXD_o: start bit, data LSB-first, optional parity, stop bit(s).
- Bit timing comes from a clock-cycle counter, so no separate baud clock is needed.
- Sits between the host-side byte source and the line driver.

Parameters:
- CLKS_PER_BIT, 8: clock cycles per serial bit; must be >= 2.
- DATA_BITS, 8: data bits per frame; range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: number of stop bits; 1 or 2.

Ports:
- clk_i  in  1  system clock, all logic on the rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- data_i  in  DATA_BITS  word to transmit; sampled only on an accepted handshake.
- valid_i  in  1  data_i holds a word to send.
- ready_o  out  1  transmitter can accept a word this cycle.
- TXD_o  out  1  serial line output; idle/mark = 1.
- busy_o  out  1  a frame is in progress (state != IDLE).
- done_o  out  1  one-cycle pulse after a frame's last stop bit completes.

Behaviour:
- Reset (rst_i=0) takes effect asynchronously, including mid-frame: TXD_o=1, ready_o=1, busy_o=0, done_o=0, state=IDLE, bit and cycle counters cleared, shift register cleared.
- All outputs are registered except ready_o, which is decoded from registered state only. There is no combinational path from valid_i to any output.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: TXD_o=1.
    - On valid_i && ready_o, data_i is loaded into the shift register and the next state is START.
    - TXD_o=0 from the cycle after acceptance (latency 1 clock).
  - START: TXD_o=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: TXD_o = shift_reg[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit.
    - After DATA_BITS bits: go to PARITY if PARITY != 0, else STOP.
  - PARITY: TXD_o = parity bit for CLKS_PER_BIT cycles.
    - Odd parity: the total count of ones (data + parity) is odd.
    - Even parity: that total is even.
    - Parity is computed from the word captured at acceptance.
  - STOP: TXD_o=1 for STOP_BITS*CLKS_PER_BIT cycles.
    - Then go to IDLE, or straight to START if a new word is accepted in the final stop cycle.
- ready_o=1 in IDLE, and also in the last clock cycle of the last stop bit. This permits back-to-back frames with no extra mark time. It is 0 at all other times.
- Frame length is exactly CLKS_PER_BIT*(1 + DATA_BITS + (PARITY!=0) + STOP_BITS) cycles.
- done_o pulses for 1 cycle in the cycle after the last stop-bit cycle. This also happens when a back-to-back frame is already starting.
- data_i/valid_i changes while ready_o=0 are ignored; the captured word is never altered mid-frame.
- busy_o=1 from the cycle after acceptance until the frame ends.
  - busy_o stays 1 continuously across back-to-back frames.
- Invalid parameter values (PARITY=3, STOP_BITS outside 1..2) are not supported; behaviour is undefined.

Test Plan:
- Reset check: hold rst_i=0 for 3 cycles -> TXD_o=1, ready_o=1, busy_o=0, done_o=0. Then release; with valid_i=0 for 20 cycles, outputs remain unchanged.
- Basic frame (defaults): send 0xA5 -> TXD_o sequence 0,1,0,1,0,0,1,0,1,1, each held exactly 8 cycles.
  - Start bit begins 1 cycle after acceptance.
  - done_o pulses 81 cycles after acceptance.
  - ready_o=0 between acceptance and the last stop cycle.
- Parity: PARITY=2, send 0x07 -> parity bit 1. PARITY=1, send 0x07 -> parity bit 0. In both cases the frame is 88 cycles.
- Back-to-back: hold valid_i=1 with 0x55 then 0xAA.
  - Second start bit begins on the cycle immediately after the 8th cycle of the first stop bit, with no extra mark.
  - busy_o stays 1 and done_o pulses once per frame.
- Reset mid-frame: assert rst_i=0 during data bit 3 -> TXD_o goes to 1 asynchronously, before the next clock edge.
  - After release, ready_o=1.
  - A new word 0x3C then transmits as a complete, correct frame.
- Data stability and 2 stop bits: STOP_BITS=2; change data_i every cycle while busy -> transmitted bits match only the word captured at acceptance, and the stop phase lasts 16 cycles.

Source files
------------

// File: rtl/nadajnik.sv
// ---------------------------------------------------------------------------
// nadajnik - UART / RS-232 serial transmitter (transmit side of odbiornik)
//
// Takes one parallel word per valid/ready handshake and shifts it out on
// TXD_o as: start bit (0), DATA_BITS data bits LSB-first, an optional parity
// bit, then STOP_BITS stop bits (1). Bit timing comes from a cycle counter
// that runs at the system clock, so no separate baud clock is needed.
//
// Ports:
//   clk_i    system clock, rising edge
//   rst_i    asynchronous reset, active low
//   data_i   word to send, captured only on an accepted handshake
//   valid_i  data_i holds a word to send
//   ready_o  transmitter accepts a word this cycle (decoded from state)
//   TXD_o    serial line, idles at mark (1)
//   busy_o   a frame is in progress
//   done_o   one-cycle pulse in the cycle after the last stop-bit cycle
// ---------------------------------------------------------------------------
module nadajnik #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 TXD_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int CYC_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 state_q, state_d;
  logic [CYC_W-1:0]       cyc_q, cyc_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   txd_q, txd_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic                   bit_end;
  logic                   last_stop;
  logic                   accept;

  // Parity bit that makes the total count of ones (data + parity) odd or even.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    if (PARITY == 1) begin
      return ~(^w);
    end
    return ^w;
  endfunction

  assign bit_end   = (cyc_q == CYC_LAST);
  assign last_stop = (state_q == S_STOP) && bit_end && (bit_q == STOP_LAST);

  // Ready also in the final stop cycle so frames can run back-to-back.
  assign ready_o = (state_q == S_IDLE) || last_stop;
  assign accept  = valid_i && ready_o;

  assign TXD_o  = txd_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // TXD is registered, so each branch loads the line level of the state
  // being entered; this puts the start bit on the line one clock after
  // acceptance.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    txd_d   = txd_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      cyc_d = bit_end ? '0 : cyc_q + CYC_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (accept) begin
          shift_d = data_i;
          par_d   = parity_of(data_i);
          state_d = S_START;
          cyc_d   = '0;
          bit_d   = '0;
          txd_d   = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
            txd_d   = shift_q[1];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
          txd_d   = 1'b1;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            done_d = 1'b1;
            bit_d  = '0;
            if (accept) begin
              shift_d = data_i;
              par_d   = parity_of(data_i);
              state_d = S_START;
              txd_d   = 1'b0;
            end else begin
              state_d = S_IDLE;
              txd_d   = 1'b1;
            end
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_nadajnik.sv
// ---------------------------------------------------------------------------
// tb_nadajnik - directed bench for nadajnik. Four instances share clock and
// reset: u0 default (8N1), u1 even parity, u2 odd parity, u3 two stop bits.
// Expected line sequences are hand-computed constants, bit i of seq being
// the i-th serial bit (start first).
// ---------------------------------------------------------------------------
module tb_nadajnik;

  logic       clk;
  logic       rst;
  logic [7:0] din [4];
  logic [3:0] vld;
  logic       t0, t1, t2, t3;
  logic       r0, r1, r2, r3;
  logic       b0, b1, b2, b3;
  logic       d0, d1, d2, d3;
  logic [3:0] txd, rdy, bsy, dn;

  int checks = 0;
  int errors = 0;

  assign txd = {t3, t2, t1, t0};
  assign rdy = {r3, r2, r1, r0};
  assign bsy = {b3, b2, b1, b0};
  assign dn  = {d3, d2, d1, d0};

  nadajnik u0 (
    .clk_i(clk), .rst_i(rst), .data_i(din[0]), .valid_i(vld[0]),
    .ready_o(r0), .TXD_o(t0), .busy_o(b0), .done_o(d0)
  );
  nadajnik #(.PARITY(2)) u1 (
    .clk_i(clk), .rst_i(rst), .data_i(din[1]), .valid_i(vld[1]),
    .ready_o(r1), .TXD_o(t1), .busy_o(b1), .done_o(d1)
  );
  nadajnik #(.PARITY(1)) u2 (
    .clk_i(clk), .rst_i(rst), .data_i(din[2]), .valid_i(vld[2]),
    .ready_o(r2), .TXD_o(t2), .busy_o(b2), .done_o(d2)
  );
  nadajnik #(.STOP_BITS(2)) u3 (
    .clk_i(clk), .rst_i(rst), .data_i(din[3]), .valid_i(vld[3]),
    .ready_o(r3), .TXD_o(t3), .busy_o(b3), .done_o(d3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a word for one edge; returns #1 after the accepting edge.
  task automatic send(input int k, input logic [7:0] w, input string tag);
    din[k] = w;
    vld[k] = 1'b1;
    chk({tag, "_rdy_pre"}, rdy[k], 1'b1);
    tick();
    vld[k] = 1'b0;
  endtask

  // Called #1 after the accepting edge; checks every cycle of a frame of
  // nb bits and returns #1 after the edge that ends the last stop cycle.
  task automatic frame(input int k, input logic [11:0] seq, input int nb,
                       input bit scramble, input string tag);
    int len;
    len = nb * 8;
    for (int i = 0; i < len; i++) begin
      chk({tag, "_txd"}, txd[k], seq[i / 8]);
      chk({tag, "_rdy"}, rdy[k], (i == len - 1));
      chk({tag, "_busy"}, bsy[k], 1'b1);
      if (i > 0) chk({tag, "_done"}, dn[k], 1'b0);
      if (scramble) begin
        din[k] = 8'($urandom);
        vld[k] = (i == len - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      end
      tick();
    end
  endtask

  task automatic idle_chk(input int k, input string tag);
    chk({tag, "_txd"}, txd[k], 1'b1);
    chk({tag, "_rdy"}, rdy[k], 1'b1);
    chk({tag, "_busy"}, bsy[k], 1'b0);
    chk({tag, "_done"}, dn[k], 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    vld = '0;
    for (int k = 0; k < 4; k++) din[k] = 8'h00;

    // Reset held for three cycles, then 20 idle cycles.
    repeat (3) tick();
    for (int k = 0; k < 4; k++) idle_chk(k, "reset");
    rst = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      for (int k = 0; k < 4; k++) idle_chk(k, "idle");
    end

    // 0xA5 on 8N1: 0,1,0,1,0,0,1,0,1,1
    send(0, 8'hA5, "a5");
    frame(0, 12'h34A, 10, 1'b0, "a5");
    chk("a5_done_pulse", dn[0], 1'b1);
    chk("a5_busy_end", bsy[0], 1'b0);
    chk("a5_rdy_end", rdy[0], 1'b1);
    chk("a5_txd_end", txd[0], 1'b1);
    tick();
    chk("a5_done_clear", dn[0], 1'b0);

    // 0x07 even parity -> parity bit 1, 88-cycle frame
    send(1, 8'h07, "even");
    frame(1, 12'h60E, 11, 1'b0, "even");
    chk("even_done_pulse", dn[1], 1'b1);
    chk("even_busy_end", bsy[1], 1'b0);
    tick();
    chk("even_done_clear", dn[1], 1'b0);

    // 0x07 odd parity -> parity bit 0
    send(2, 8'h07, "odd");
    frame(2, 12'h40E, 11, 1'b0, "odd");
    chk("odd_done_pulse", dn[2], 1'b1);
    chk("odd_busy_end", bsy[2], 1'b0);
    tick();
    chk("odd_done_clear", dn[2], 1'b0);

    // Back-to-back 0x55 then 0xAA with valid held high.
    din[0] = 8'h55;
    vld[0] = 1'b1;
    chk("b2b_rdy_pre", rdy[0], 1'b1);
    tick();
    din[0] = 8'hAA;
    frame(0, 12'h2AA, 10, 1'b0, "b2b55");
    chk("b2b_done_mid", dn[0], 1'b1);
    chk("b2b_busy_mid", bsy[0], 1'b1);
    chk("b2b_rdy_mid", rdy[0], 1'b0);
    vld[0] = 1'b0;
    frame(0, 12'h354, 10, 1'b0, "b2bAA");
    chk("b2b_done_end", dn[0], 1'b1);
    chk("b2b_busy_end", bsy[0], 1'b0);
    tick();
    chk("b2b_done_clear", dn[0], 1'b0);

    // Reset during data bit 3 of 0xF0 (that bit is 0 on the line).
    send(0, 8'hF0, "mid");
    repeat (35) tick();
    chk("mid_txd_bit3", txd[0], 1'b0);
    rst = 1'b0;
    #1;
    chk("mid_txd_async", txd[0], 1'b1);
    chk("mid_rdy_async", rdy[0], 1'b1);
    chk("mid_busy_async", bsy[0], 1'b0);
    chk("mid_done_async", dn[0], 1'b0);
    tick();
    rst = 1'b1;
    tick();
    chk("mid_rdy_release", rdy[0], 1'b1);
    // 0x3C: 0,0,0,1,1,1,1,0,0,1
    send(0, 8'h3C, "x3c");
    frame(0, 12'h278, 10, 1'b0, "x3c");
    chk("x3c_done_pulse", dn[0], 1'b1);
    chk("x3c_busy_end", bsy[0], 1'b0);
    tick();

    // Two stop bits, data_i/valid_i churning mid-frame. 0xC3 -> 0,1,1,0,0,0,0,1,1,1,1
    send(3, 8'hC3, "stop2");
    frame(3, 12'h786, 11, 1'b1, "stop2");
    chk("stop2_done_pulse", dn[3], 1'b1);
    chk("stop2_busy_end", bsy[3], 1'b0);
    chk("stop2_txd_end", txd[3], 1'b1);
    tick();
    chk("stop2_done_clear", dn[3], 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
